// File: rtl/i2s_rcvr_ctrl.sv
// I2S receiver sequencer: oversamples SCK/WS/SD, drives an external shift register and captures L/R words.
// Optional SCK-loss timeout enabled by defining I2S_RCVR_CTRL_TIMEOUT_EN.
module i2s_rcvr_ctrl #(
   parameter int SR_WIDTH       = 32,
   parameter int SAMPLE_BITS    = 24,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   enable,
   input  logic                   i2s_sck,
   input  logic                   i2s_ws,
   input  logic                   i2s_sd,
   output logic                   shift,
   output logic                   sr_data_in,
   input  logic [SR_WIDTH-1:0]    sr_data,
   output logic [SAMPLE_BITS-1:0] left_sample,
   output logic [SAMPLE_BITS-1:0] right_sample,
   output logic                   sample_valid,
   output logic                   sample_ch,
   output logic                   frame_err
);

   localparam int CW = $clog2(SAMPLE_BITS + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(SAMPLE_BITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_BITS - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, LOAD} state_t;

   state_t                 state_reg, state_next;
   logic [CW-1:0]          bit_cnt_reg, bit_cnt_next;
   logic                   sck_meta_reg, sck_s_reg, sck_d_reg;
   logic                   ws_meta_reg, ws_s_reg, ws_cur_reg;
   logic                   sd_meta_reg, sd_s_reg;
   logic                   shift_reg, shift_next;
   logic                   sd_out_reg, sd_out_next;
   logic                   cap_ch_reg, cap_ch_next;
   logic                   ch_reg, ch_next;
   logic                   valid_reg, valid_next;
   logic                   err_reg, err_next;
   logic [SAMPLE_BITS-1:0] left_reg, left_next;
   logic [SAMPLE_BITS-1:0] right_reg, right_next;
   logic                   sck_rise, ws_edge, to_hit, in_word;
   logic                   sr_unused;

   // Upper shift-register bits belong to wider slots and are never captured.
   assign sr_unused = ^sr_data;

   assign sck_rise = sck_s_reg & ~sck_d_reg;
   assign ws_edge  = sck_rise & (ws_s_reg != ws_cur_reg);
   assign in_word  = bit_cnt_reg < CNT_FULL;

`ifdef I2S_RCVR_CTRL_TIMEOUT_EN
   logic [15:0] to_cnt_reg;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         to_cnt_reg <= '0;
      end else if (state_reg == IDLE || sck_rise) begin
         to_cnt_reg <= '0;
      end else if (to_cnt_reg != 16'hFFFF) begin
         to_cnt_reg <= to_cnt_reg + 16'd1;
      end
   end

   assign to_hit = (state_reg != IDLE) && !sck_rise && (to_cnt_reg == 16'(TIMEOUT_CYCLES - 1));
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg    <= IDLE;
         bit_cnt_reg  <= '0;
         sck_meta_reg <= 1'b0;
         sck_s_reg    <= 1'b0;
         sck_d_reg    <= 1'b0;
         ws_meta_reg  <= 1'b0;
         ws_s_reg     <= 1'b0;
         ws_cur_reg   <= 1'b0;
         sd_meta_reg  <= 1'b0;
         sd_s_reg     <= 1'b0;
         shift_reg    <= 1'b0;
         sd_out_reg   <= 1'b0;
         cap_ch_reg   <= 1'b0;
         ch_reg       <= 1'b0;
         valid_reg    <= 1'b0;
         err_reg      <= 1'b0;
         left_reg     <= '0;
         right_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         bit_cnt_reg  <= bit_cnt_next;
         sck_meta_reg <= i2s_sck;
         sck_s_reg    <= sck_meta_reg;
         sck_d_reg    <= sck_s_reg;
         ws_meta_reg  <= i2s_ws;
         ws_s_reg     <= ws_meta_reg;
         sd_meta_reg  <= i2s_sd;
         sd_s_reg     <= sd_meta_reg;
         if (sck_rise) begin
            ws_cur_reg <= ws_s_reg;
         end
         shift_reg    <= shift_next;
         sd_out_reg   <= sd_out_next;
         cap_ch_reg   <= cap_ch_next;
         ch_reg       <= ch_next;
         valid_reg    <= valid_next;
         err_reg      <= err_next;
         left_reg     <= left_next;
         right_reg    <= right_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = 1'b0;
      sd_out_next  = 1'b0;
      cap_ch_next  = cap_ch_reg;
      ch_next      = ch_reg;
      valid_next   = 1'b0;
      err_next     = 1'b0;
      left_next    = left_reg;
      right_next   = right_reg;

      if (!enable) begin
         state_next   = IDLE;
         bit_cnt_next = '0;
      end else if (to_hit) begin
         state_next   = IDLE;
         bit_cnt_next = '0;
         err_next     = 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               // Only a right->left transition marks a frame start; its bit is the previous LSB.
               if (ws_edge && ws_cur_reg && !ws_s_reg) begin
                  state_next   = SHIFT;
                  bit_cnt_next = '0;
               end
            end
            SHIFT: begin
               if (sck_rise) begin
                  if (in_word) begin
                     shift_next  = 1'b1;
                     sd_out_next = sd_s_reg;
                  end
                  if (ws_edge) begin
                     bit_cnt_next = '0;
                     cap_ch_next  = ws_cur_reg;
                     if (bit_cnt_reg >= CNT_LAST) begin
                        state_next = CAPTURE;
                     end else begin
                        err_next = 1'b1;
                     end
                  end else if (in_word) begin
                     bit_cnt_next = bit_cnt_reg + CW'(1);
                  end
               end
            end
            CAPTURE: begin
               // The final shift lands this cycle; sr_data is valid next cycle.
               state_next = LOAD;
            end
            LOAD: begin
               if (cap_ch_reg) begin
                  right_next = sr_data[SAMPLE_BITS-1:0];
               end else begin
                  left_next = sr_data[SAMPLE_BITS-1:0];
               end
               ch_next    = cap_ch_reg;
               valid_next = 1'b1;
               state_next = SHIFT;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign shift        = shift_reg;
   assign sr_data_in   = sd_out_reg;
   assign left_sample  = left_reg;
   assign right_sample = right_reg;
   assign sample_valid = valid_reg;
   assign sample_ch    = ch_reg;
   assign frame_err    = err_reg;

endmodule
